gilbert_elliott_channel: RTL and testbench
==========================================

# gilbert_elliott_channel

Parametrised two-state Gilbert–Elliott channel model for the link-level test chain. It sits between the transmitter sample stream and the receiver. It passes samples through a one-deep valid/ready register and injects single-bit errors at a per-state programmable rate. State dwell, transition probabilities, error rates and per-state SNR reporting are all runtime-configurable, and saturating statistics counters support BER measurement in the bench.

## Interface
Parameters:
- DATA_W, 16, sample width
- PROB_W, 8, width of all probability fields (probability = value / 2^PROB_W; all-ones = certain)
- TS_W, 16, dwell-interval counter width
- SEED, 32'hACE1_2024, LFSR reset value (nonzero)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cfg_p_gb  in  PROB_W  Good→Bad transition probability per tick
- cfg_p_bg  in  PROB_W  Bad→Good transition probability per tick
- cfg_ber_g  in  PROB_W  per-sample error probability in Good
- cfg_ber_b  in  PROB_W  per-sample error probability in Bad
- cfg_ts  in  TS_W  dwell interval; tick every cfg_ts+1 cycles
- cfg_snr_g  in  5  SNR reported in Good
- cfg_snr_b  in  5  SNR reported in Bad
- in_valid  in  1  input sample valid
- in_ready  out  1  input accepted when in_valid & in_ready
- in_data  in  DATA_W  input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_W  possibly corrupted sample
- out_err  out  1  this output sample was corrupted
- state  out  1  0 = Good, 1 = Bad
- snr  out  5  state ? cfg_snr_b : cfg_snr_g (combinational)
- clr_stats  in  1  synchronous clear of statistics
- err_count  out  16  saturating count of corrupted transfers accepted
- bad_cycles  out  16  saturating count of cycles with state = 1

## Operation
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances every cycle and loads SEED on reset. Slices: rT = rand[PROB_W-1:0] (transition), rE = rand[2*PROB_W-1:PROB_W] (error), rP = rand[31 -: POS_W] mod DATA_W (flip position), POS_W = clog2(DATA_W). Constraint: 2*PROB_W + POS_W ≤ 32.
- Event "hit(p, r)": p == all-ones, or r < p. p = 0 never hits.
- Dwell counter: increments each cycle. Tick when count ≥ cfg_ts, and count ← 0 on that cycle. cfg_ts = 0 gives a tick every cycle. Lowering cfg_ts below count causes an immediate tick.
- On a tick: Good→Bad if hit(cfg_p_gb, rT); Bad→Good if hit(cfg_p_bg, rT). Otherwise the state holds.
- Datapath: in_ready = !out_valid | out_ready. On acceptance: out_data ← in_data ^ (e ? 1<<rP : 0) and out_err ← e, where e = hit(state ? cfg_ber_b : cfg_ber_g, rE).
- out_valid clears when out_ready and nothing is accepted.
- The error decision uses the registered (pre-tick) state when a tick and an acceptance share a cycle.
- err_count increments on an acceptance with e = 1. bad_cycles increments each cycle state = 1. Both saturate at 16'hFFFF. clr_stats has priority over increment.

## Timing
- Reset values: state 0, count 0, out_valid 0, out_data 0, out_err 0, err_count 0, bad_cycles 0, LFSR = SEED. in_ready is 1 after reset.
- Latency: sample accepted at edge N is visible on out_data after edge N. Full throughput of 1 sample/cycle is sustained when out_ready = 1.
- Backpressure: while out_valid & !out_ready, out_data/out_err are held stable and in_ready = 0.
- State change is visible the cycle after the tick. snr follows state in the same cycle.
- Reset mid-stream: a held output is discarded. Identical stimulus after reset reproduces identical corruption.

## Structure
- Package gilbert_pkg: state encoding (ST_GOOD/ST_BAD), LFSR polynomial and width constant, stats width, hit() function.
- Sub-module lfsr32: parametrised seed, free-running, asynchronous reset, 32-bit output.

## Test plan
- p_gb = 0, ber_g = 0, out_ready = 1, in_data = 0..99 → out_data = 0..99 one cycle later, state stays 0, err_count = 0.
- p_gb = 8'hFF, cfg_ts = 3, snr_g = 21, snr_b = 9 → state = 1 and snr = 9 four cycles after reset release; with p_bg = 8'hFF, state returns to 0 after a further 4 cycles.
- Bad state, ber_b = 8'hFF, in_data = 16'h0000 for 50 samples → each out_data has exactly one bit set, out_err = 1, err_count = 50.
- Hold out_ready = 0 for 5 cycles with a sample pending → out_data stable, in_ready = 0, err_count unchanged, no sample lost or duplicated.
- Preload err_count to 16'hFFFF via forced errors → it stays at 16'hFFFF; clr_stats coincident with an error → 0.
- Assert reset while out_valid = 1 → out_valid 0, state 0, count 0; replaying the same stimulus gives a bit-identical output sequence.

Source files
------------

// File: rtl/gilbert_elliott_channel_pkg.sv
// Shared types and helpers for the Gilbert-Elliott channel model:
// state encoding, LFSR constants, statistics width and the probability hit test.
package gilbert_pkg;

  typedef enum logic {
    ST_GOOD = 1'b0,
    ST_BAD  = 1'b1
  } ch_state_e;

  localparam int unsigned            LFSR_W    = 32;
  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0]      LFSR_POLY = 32'h8020_0003;

  localparam int unsigned            STATS_W   = 16;
  localparam logic [STATS_W-1:0]     STATS_MAX = {STATS_W{1'b1}};

  // Probability fields are zero-extended to this width before comparison
  localparam int unsigned            HIT_W     = 16;

  // p == all-ones always hits; p == 0 never hits; otherwise hit when r < p
  function automatic logic hit(input logic [HIT_W-1:0] p,
                               input logic [HIT_W-1:0] r,
                               input logic [HIT_W-1:0] full);
    return (p == full) || (r < p);
  endfunction

endpackage

// File: rtl/gilbert_elliott_channel_lfsr32.sv
// Free-running 32-bit Galois LFSR, loaded with SEED on reset.
module lfsr32
  import gilbert_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2024
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= (value >> 1) ^ (value[0] ? LFSR_POLY : '0);
    end
  end

endmodule

// File: rtl/gilbert_elliott_channel.sv
// Two-state Gilbert-Elliott channel: one-deep valid/ready pipe stage that flips
// a single random bit per sample at a state-dependent rate, plus BER statistics.
module gilbert_elliott_channel
  import gilbert_pkg::*;
#(
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       PROB_W = 8,
  parameter int unsigned       TS_W   = 16,
  parameter logic [LFSR_W-1:0] SEED   = 32'hACE1_2024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PROB_W-1:0]   cfg_p_gb,
  input  logic [PROB_W-1:0]   cfg_p_bg,
  input  logic [PROB_W-1:0]   cfg_ber_g,
  input  logic [PROB_W-1:0]   cfg_ber_b,
  input  logic [TS_W-1:0]     cfg_ts,
  input  logic [4:0]          cfg_snr_g,
  input  logic [4:0]          cfg_snr_b,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_err,
  output logic                state,
  output logic [4:0]          snr,
  input  logic                clr_stats,
  output logic [STATS_W-1:0]  err_count,
  output logic [STATS_W-1:0]  bad_cycles
);

  localparam int unsigned      POS_W     = $clog2(DATA_W);
  localparam logic [HIT_W-1:0] PROB_FULL = HIT_W'({PROB_W{1'b1}});

  // Random source and its slices
  logic [LFSR_W-1:0] rnd;
  logic [LFSR_W-1:0] unused_rnd;
  logic [PROB_W-1:0] r_t;
  logic [PROB_W-1:0] r_e;
  logic [POS_W-1:0]  pos_raw;
  logic [POS_W-1:0]  flip_pos;

  lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (rnd)
  );

  // Bits between the error slice and the position slice carry no meaning
  assign unused_rnd = rnd;
  assign r_t        = rnd[PROB_W-1:0];
  assign r_e        = rnd[2*PROB_W-1:PROB_W];
  assign pos_raw    = rnd[LFSR_W-1 -: POS_W];
  assign flip_pos   = POS_W'(32'(pos_raw) % DATA_W);

  // Dwell counter: tick on reaching cfg_ts, including when cfg_ts is lowered below it
  logic [TS_W-1:0] dwell_cnt;
  logic            tick;

  assign tick = (dwell_cnt >= cfg_ts);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
    end else if (tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + TS_W'(1);
    end
  end

  // Channel state machine
  ch_state_e cur_state;
  ch_state_e nxt_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_GOOD;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    if (tick) begin
      case (cur_state)
        ST_GOOD: if (hit(HIT_W'(cfg_p_gb), HIT_W'(r_t), PROB_FULL)) nxt_state = ST_BAD;
        ST_BAD:  if (hit(HIT_W'(cfg_p_bg), HIT_W'(r_t), PROB_FULL)) nxt_state = ST_GOOD;
        default: nxt_state = ST_GOOD;
      endcase
    end
  end

  always_comb begin
    state = cur_state;
    snr   = (cur_state == ST_BAD) ? cfg_snr_b : cfg_snr_g;
  end

  // Datapath; the error decision always uses the registered state
  logic              accept;
  logic [PROB_W-1:0] ber_sel;
  logic              err_hit;
  logic [DATA_W-1:0] flip_mask;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign ber_sel   = (cur_state == ST_BAD) ? cfg_ber_b : cfg_ber_g;
  assign err_hit   = hit(HIT_W'(ber_sel), HIT_W'(r_e), PROB_FULL);
  assign flip_mask = err_hit ? (DATA_W'(1) << flip_pos) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ flip_mask;
      out_err   <= err_hit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating statistics; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count  <= '0;
      bad_cycles <= '0;
    end else if (clr_stats) begin
      err_count  <= '0;
      bad_cycles <= '0;
    end else begin
      if (accept && err_hit && (err_count != STATS_MAX)) begin
        err_count <= err_count + STATS_W'(1);
      end
      if ((cur_state == ST_BAD) && (bad_cycles != STATS_MAX)) begin
        bad_cycles <= bad_cycles + STATS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gilbert_elliott_channel.sv
// Directed self-checking bench for gilbert_elliott_channel.
module tb_gilbert_elliott_channel;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PROB_W = 8;
  localparam int unsigned TS_W   = 16;
  localparam int          SEQ_N  = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [PROB_W-1:0] cfg_p_gb, cfg_p_bg, cfg_ber_g, cfg_ber_b;
  logic [TS_W-1:0]   cfg_ts;
  logic [4:0]        cfg_snr_g, cfg_snr_b;
  logic              in_valid, in_ready, out_valid, out_ready, out_err, state, clr_stats;
  logic [DATA_W-1:0] in_data, out_data;
  logic [4:0]        snr;
  logic [15:0]       err_count, bad_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] seq_data  [SEQ_N];
  logic              seq_err   [SEQ_N];
  logic              seq_state [SEQ_N];
  logic              seq_valid [SEQ_N];

  always #5 clk = ~clk;

  gilbert_elliott_channel #(
    .DATA_W (DATA_W),
    .PROB_W (PROB_W),
    .TS_W   (TS_W),
    .SEED   (32'hACE1_2024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_p_gb   (cfg_p_gb),
    .cfg_p_bg   (cfg_p_bg),
    .cfg_ber_g  (cfg_ber_g),
    .cfg_ber_b  (cfg_ber_b),
    .cfg_ts     (cfg_ts),
    .cfg_snr_g  (cfg_snr_g),
    .cfg_snr_b  (cfg_snr_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .state      (state),
    .snr        (snr),
    .clr_stats  (clr_stats),
    .err_count  (err_count),
    .bad_cycles (bad_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over two edges and release it 1 time unit after an edge
  task automatic apply_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] p_gb, input logic [7:0] p_bg,
                         input logic [7:0] ber_g, input logic [7:0] ber_b,
                         input logic [15:0] ts);
    cfg_p_gb  = p_gb;
    cfg_p_bg  = p_bg;
    cfg_ber_g = ber_g;
    cfg_ber_b = ber_b;
    cfg_ts    = ts;
    cfg_snr_g = 5'd21;
    cfg_snr_b = 5'd9;
  endtask

  task automatic test_reset();
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 16'd0);
    apply_reset();
    n_checks++;
    if (state !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0 || out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0b out_valid=%0b out_err=%0b out_data=%h, expected 0/0/0/0000",
               state, out_valid, out_err, out_data);
    end
    n_checks++;
    if (err_count !== 16'h0 || bad_cycles !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_stats: err_count=%h bad_cycles=%h, expected 0000/0000", err_count, bad_cycles);
    end
    n_checks++;
    if (in_ready !== 1'b1 || snr !== 5'd21) begin
      n_fail++;
      $display("FAIL reset_ready_snr: in_ready=%0b snr=%0d, expected 1/21", in_ready, snr);
    end
  endtask

  task automatic test_passthrough();
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 16'd0);
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      in_data  = DATA_W'(i);
      in_valid = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_err !== 1'b0 || state !== 1'b0) begin
        n_fail++;
        $display("FAIL passthrough[%0d]: valid=%0b data=%0d err=%0b state=%0b, expected 1/%0d/0/0",
                 i, out_valid, out_data, out_err, state, i);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== 16'h0 || bad_cycles !== 16'h0) begin
      n_fail++;
      $display("FAIL passthrough_drain: valid=%0b err_count=%0d bad_cycles=%0d, expected 0/0/0",
               out_valid, err_count, bad_cycles);
    end
  endtask

  task automatic test_state_transitions();
    set_cfg(8'hFF, 8'h00, 8'h00, 8'h00, 16'd3);
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++;
      if (state !== 1'b0) begin
        n_fail++;
        $display("FAIL dwell_good_cycle%0d: state=%0b, expected 0", c, state);
      end
    end
    step();
    n_checks++;
    if (state !== 1'b1 || snr !== 5'd9) begin
      n_fail++;
      $display("FAIL enter_bad: state=%0b snr=%0d, expected 1/9", state, snr);
    end
    cfg_p_bg = 8'hFF;
    for (int c = 5; c <= 7; c++) begin
      step();
      n_checks++;
      if (state !== 1'b1) begin
        n_fail++;
        $display("FAIL dwell_bad_cycle%0d: state=%0b, expected 1", c, state);
      end
    end
    step();
    n_checks++;
    if (state !== 1'b0 || snr !== 5'd21 || bad_cycles !== 16'd4) begin
      n_fail++;
      $display("FAIL return_good: state=%0b snr=%0d bad_cycles=%0d, expected 0/21/4", state, snr, bad_cycles);
    end
    // Lowering cfg_ts below the running count forces an immediate tick
    cfg_ts = 16'd100;
    repeat (5) step();
    n_checks++;
    if (state !== 1'b0) begin
      n_fail++;
      $display("FAIL long_dwell: state=%0b, expected 0", state);
    end
    cfg_ts = 16'd2;
    step();
    n_checks++;
    if (state !== 1'b1) begin
      n_fail++;
      $display("FAIL lowered_ts_tick: state=%0b, expected 1", state);
    end
  endtask

  task automatic test_bad_errors();
    set_cfg(8'hFF, 8'h00, 8'h00, 8'hFF, 16'd0);
    apply_reset();
    step();
    n_checks++;
    if (state !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_entry: state=%0b, expected 1", state);
    end
    for (int i = 0; i < 50; i++) begin
      in_data  = 16'h0000;
      in_valid = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || $countones(out_data) != 1 || out_err !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_error[%0d]: valid=%0b data=%h err=%0b, expected 1/one-hot/1",
                 i, out_valid, out_data, out_err);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (err_count !== 16'd50) begin
      n_fail++;
      $display("FAIL bad_err_count: err_count=%0d, expected 50", err_count);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    set_cfg(8'hFF, 8'h00, 8'h00, 8'hFF, 16'd0);
    apply_reset();
    step();
    in_data  = 16'h00F0;
    in_valid = 1'b1;
    step();
    held = out_data;
    n_checks++;
    if (out_valid !== 1'b1 || $countones(held ^ 16'h00F0) != 1 || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: valid=%0b data=%h err=%0b, expected 1/00F0 with one flip/1",
               out_valid, held, out_err);
    end
    in_data   = 16'h0F00;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || err_count !== 16'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%0b data=%h in_ready=%0b err_count=%0d, expected 1/%h/0/1",
                 k, out_valid, out_data, in_ready, err_count, held);
      end
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || $countones(out_data ^ 16'h0F00) != 1) begin
      n_fail++;
      $display("FAIL bp_second: valid=%0b data=%h, expected 1/0F00 with one flip", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%0b err_count=%0d, expected 0/2", out_valid, err_count);
    end
  endtask

  task automatic test_saturation();
    set_cfg(8'hFF, 8'h00, 8'h00, 8'hFF, 16'd0);
    apply_reset();
    step();
    in_data  = 16'h0000;
    in_valid = 1'b1;
    repeat (65535) step();
    n_checks++;
    if (err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: err_count=%h, expected FFFF", err_count);
    end
    repeat (3) step();
    n_checks++;
    if (err_count !== 16'hFFFF || bad_cycles !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: err_count=%h bad_cycles=%h, expected FFFF/FFFF", err_count, bad_cycles);
    end
    clr_stats = 1'b1;
    step();
    n_checks++;
    if (err_count !== 16'h0 || bad_cycles !== 16'h0 || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_priority: err_count=%h bad_cycles=%h out_err=%0b, expected 0000/0000/1",
               err_count, bad_cycles, out_err);
    end
    clr_stats = 1'b0;
    step();
    n_checks++;
    if (err_count !== 16'd1 || bad_cycles !== 16'd1) begin
      n_fail++;
      $display("FAIL post_clr: err_count=%0d bad_cycles=%0d, expected 1/1", err_count, bad_cycles);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic              ov_m;
    logic              acc;
    logic [DATA_W-1:0] last_in;
    set_cfg(8'h30, 8'h50, 8'h40, 8'hC0, 16'd2);
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      ov_m    = 1'b0;
      last_in = '0;
      for (int i = 0; i < SEQ_N; i++) begin
        in_data   = DATA_W'(16'hA5A5 ^ 16'(i * 257));
        in_valid  = (i % 5) != 4;
        out_ready = (i % 7) != 3;
        acc       = in_valid && (!ov_m || out_ready);
        step();
        if (acc) last_in = in_data;
        ov_m = acc ? 1'b1 : (out_ready ? 1'b0 : ov_m);
        n_checks++;
        if (out_valid !== ov_m ||
            (ov_m && ($countones(out_data ^ last_in) != (out_err ? 1 : 0)))) begin
          n_fail++;
          $display("FAIL stream_p%0d[%0d]: valid=%0b data=%h err=%0b, expected valid=%0b from input %h",
                   pass, i, out_valid, out_data, out_err, ov_m, last_in);
        end
        if (pass == 0) begin
          seq_data[i]  = out_data;
          seq_err[i]   = out_err;
          seq_state[i] = state;
          seq_valid[i] = out_valid;
        end else begin
          n_checks++;
          if (out_data !== seq_data[i] || out_err !== seq_err[i] ||
              state !== seq_state[i] || out_valid !== seq_valid[i]) begin
            n_fail++;
            $display("FAIL replay[%0d]: data=%h err=%0b state=%0b valid=%0b, expected %h/%0b/%0b/%0b",
                     i, out_data, out_err, state, out_valid,
                     seq_data[i], seq_err[i], seq_state[i], seq_valid[i]);
          end
        end
      end
      if (pass == 0) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL midreset_pending: out_valid=%0b, expected 1", out_valid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || state !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL midreset_clear: valid=%0b state=%0b data=%h in_ready=%0b, expected 0/0/0000/1",
                   out_valid, state, out_data, in_ready);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 16'd0);
    test_reset();
    test_passthrough();
    test_state_transitions();
    test_bad_errors();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
